// File: rtl/timer_ctrl.sv
// Machine timer: 64-bit mtime/mtimecmp with prescaler and a req/ack register port.
// Bus latency 1 cycle (ack + rdata the cycle after accept); one access in flight, no stalls.
module timer_ctrl #(
    parameter logic [7:0]  PRESCALE_RST = 8'd0,
    parameter logic [63:0] CMP_RST      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        timer_interrupt
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        en, auto_reload, irq_en;
    logic [7:0]  prescale;
    logic [7:0]  pcnt;
    logic [63:0] mtime, mtimecmp;
    logic [31:0] hi_shadow;
    logic        pending;
    logic [31:0] rd_val;
    logic        addr_unused;

    assign addr_unused = ^addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ack       = 1'b0;
        case (state)
            IDLE: if (req) begin
                accept    = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                ack       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic [2:0] word;
    logic       wr, rd;
    logic       wr_ctrl, wr_status, wr_mlo, wr_mhi, wr_clo, wr_chi, rd_mlo;
    logic       tick, cmp_hit;

    assign word      = addr[4:2];
    assign wr        = accept & we;
    assign rd        = accept & ~we;
    assign wr_ctrl   = wr && (word == 3'd0);
    assign wr_status = wr && (word == 3'd1);
    assign wr_mlo    = wr && (word == 3'd2);
    assign wr_mhi    = wr && (word == 3'd3);
    assign wr_clo    = wr && (word == 3'd4);
    assign wr_chi    = wr && (word == 3'd5);
    assign rd_mlo    = rd && (word == 3'd2);

    assign tick            = en && (pcnt == prescale);
    assign cmp_hit         = mtime >= mtimecmp;
    assign timer_interrupt = pending & irq_en;

    always_comb begin
        rd_val = 32'd0;
        case (word)
            3'd0: rd_val = {16'd0, prescale, 5'd0, irq_en, auto_reload, en};
            3'd1: rd_val = {31'd0, pending};
            3'd2: rd_val = mtime[31:0];
            3'd3: rd_val = hi_shadow;
            3'd4: rd_val = mtimecmp[31:0];
            3'd5: rd_val = mtimecmp[63:32];
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= PRESCALE_RST;
            mtimecmp    <= CMP_RST;
            rdata       <= 32'd0;
            hi_shadow   <= 32'd0;
        end else begin
            if (wr_ctrl) begin
                en          <= wdata[0];
                auto_reload <= wdata[1];
                irq_en      <= wdata[2];
                prescale    <= wdata[15:8];
            end
            if (wr_clo) mtimecmp[31:0]  <= wdata;
            if (wr_chi) mtimecmp[63:32] <= wdata;
            if (rd)     rdata           <= rd_val;
            // Capturing the high half here makes a LO-then-HI read pair coherent.
            if (rd_mlo) hi_shadow       <= mtime[63:32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt    <= 8'd0;
            mtime   <= 64'd0;
            pending <= 1'b0;
        end else begin
            if (wr_ctrl || !en || tick) pcnt <= 8'd0;
            else                        pcnt <= pcnt + 8'd1;

            // A software write to either half takes precedence over the tick.
            if (wr_mlo || wr_mhi) begin
                if (wr_mlo) mtime[31:0]  <= wdata;
                if (wr_mhi) mtime[63:32] <= wdata;
            end else if (tick) begin
                mtime <= (auto_reload && cmp_hit) ? 64'd0 : mtime + 64'd1;
            end

            if (en && cmp_hit)             pending <= 1'b1;
            else if (wr_status && wdata[0]) pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed-random bench for timer_ctrl; expected values come from closed-form timer arithmetic.
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ack;
    logic        timer_interrupt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    timer_ctrl #(.PRESCALE_RST(8'd0), .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .timer_interrupt(timer_interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge one cycle after the ack cycle.
    task automatic bus(input bit w, input logic [4:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int acc);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        check("ack_pulse", {63'd0, ack}, 64'd1);
        rd = rdata;
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        check("ack_single", {63'd0, ack}, 64'd0);
    endtask

    task automatic goto_accept(input int t);
        while (cyc < t - 1) @(negedge clk);
    endtask

    // mtime seen by a read accepted at edge a, counting from a CTRL write (en) at edge e.
    function automatic logic [63:0] exp_mt(input logic [63:0] s, input int e, input int a, input int p);
        return s + 64'((a - e - 1) / (p + 1));
    endfunction

    // Auto-reload with P=0 and mtime=0 at enable: mtime before edge e+n is (n-1) mod (c+1).
    function automatic bit set_cond(input int n, input int c);
        return (n >= 1) && (((n - 1) % (c + 1)) == c);
    endfunction

    logic [31:0] rd;
    logic [63:0] st, ex;
    int acc, e, p, c, n, t;
    bit exp_pend;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ack", {63'd0, ack}, 64'd0);
        check("rst_rdata", {32'd0, rdata}, 64'd0);
        check("rst_irq", {63'd0, timer_interrupt}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        bus(0, 5'h00, 0, rd, acc); check("def_ctrl", {32'd0, rd}, 64'h0);
        bus(0, 5'h14, 0, rd, acc); check("def_cmp_hi", {32'd0, rd}, 64'hFFFF_FFFF);
        bus(0, 5'h10, 0, rd, acc); check("def_cmp_lo", {32'd0, rd}, 64'hFFFF_FFFF);
        bus(0, 5'h04, 0, rd, acc); check("def_status", {32'd0, rd}, 64'h0);
        bus(0, 5'h08, 0, rd, acc); check("def_mtime_lo", {32'd0, rd}, 64'h0);

        // Prescaler: first pass is the P=3, 40-cycle case; the rest randomize P, start and wait.
        for (int it = 0; it < 5; it++) begin
            p  = (it == 0) ? 3 : int'($urandom_range(0, 6));
            st = (it == 0) ? 64'd0 : {32'($urandom_range(0, 3)), 32'($urandom)};
            bus(1, 5'h00, 0, rd, acc);
            bus(1, 5'h08, st[31:0], rd, acc);
            bus(1, 5'h0C, st[63:32], rd, acc);
            bus(1, 5'h00, {16'd0, 8'(p), 8'h01}, rd, e);
            t = (it == 0) ? e + 41 : e + 2 + int'($urandom_range(0, 40));
            goto_accept(t);
            bus(0, 5'h08, 0, rd, acc);
            ex = exp_mt(st, e, acc, p);
            check("presc_lo", {32'd0, rd}, {32'd0, ex[31:0]});
            if (it == 0) check("presc_40cyc", {32'd0, rd}, 64'd10);
            bus(0, 5'h0C, 0, rd, acc);
            check("presc_hi_shadow", {32'd0, rd}, {32'd0, ex[63:32]});
            bus(0, 5'h04, 0, rd, acc);
            check("presc_no_pend", {32'd0, rd}, 64'd0);
        end

        // Periodic auto-reload interrupt with a random compare value.
        for (int it = 0; it < 3; it++) begin
            c = (it == 0) ? 4 : int'($urandom_range(2, 7));
            bus(1, 5'h00, 0, rd, acc);
            bus(1, 5'h08, 0, rd, acc);
            bus(1, 5'h0C, 0, rd, acc);
            bus(1, 5'h10, 32'(c), rd, acc);
            bus(1, 5'h14, 0, rd, acc);
            bus(1, 5'h04, 1, rd, acc);
            bus(1, 5'h00, 32'h07, rd, e);
            exp_pend = 1'b0;
            t = 2 * (c + 1) + int'($urandom_range(0, c));
            for (int k = 0; k < t; k++) begin
                n = cyc - e;
                if (set_cond(n, c)) exp_pend = 1'b1;
                check("reload_irq", {63'd0, timer_interrupt}, {63'd0, exp_pend});
                @(negedge clk);
            end
            bus(1, 5'h04, 1, rd, acc);
            exp_pend = set_cond(acc - e, c);
            for (int k = 0; k < 2 * (c + 1) + 1; k++) begin
                n = cyc - e;
                if (set_cond(n, c)) exp_pend = 1'b1;
                check("reload_irq_after_clr", {63'd0, timer_interrupt}, {63'd0, exp_pend});
                @(negedge clk);
            end
        end

        // Coherent 64-bit read across a low-word carry.
        st = 64'h0000_0000_FFFF_FFFF;
        bus(1, 5'h00, 0, rd, acc);
        bus(1, 5'h10, 32'hFFFF_FFFF, rd, acc);
        bus(1, 5'h14, 32'hFFFF_FFFF, rd, acc);
        bus(1, 5'h0C, st[63:32], rd, acc);
        bus(1, 5'h08, st[31:0], rd, acc);
        bus(1, 5'h00, 32'h0301, rd, e);
        bus(0, 5'h08, 0, rd, acc);
        check("wrap_lo_pre", {32'd0, rd}, 64'hFFFF_FFFF);
        goto_accept(e + 7);
        bus(0, 5'h0C, 0, rd, acc);
        check("wrap_hi_shadow", {32'd0, rd}, 64'd0);
        bus(0, 5'h08, 0, rd, acc);
        ex = exp_mt(st, e, acc, 3);
        check("wrap_lo_post", {32'd0, rd}, {32'd0, ex[31:0]});
        bus(0, 5'h0C, 0, rd, acc);
        check("wrap_hi_post", {32'd0, rd}, 64'd1);

        // Non-reload: compare stays true, so a clear is overridden by the set.
        bus(1, 5'h00, 0, rd, acc);
        bus(1, 5'h08, 0, rd, acc);
        bus(1, 5'h0C, 0, rd, acc);
        bus(1, 5'h10, 2, rd, acc);
        bus(1, 5'h14, 0, rd, acc);
        bus(1, 5'h04, 1, rd, acc);
        bus(1, 5'h00, 32'h05, rd, e);
        goto_accept(e + 6);
        bus(1, 5'h04, 0, rd, acc);
        bus(0, 5'h04, 0, rd, acc);
        check("sticky_wr0", {32'd0, rd}, 64'd1);
        bus(1, 5'h04, 1, rd, acc);
        check("sticky_irq", {63'd0, timer_interrupt}, 64'd1);
        bus(0, 5'h04, 0, rd, acc);
        check("sticky_reset", {32'd0, rd}, 64'd1);
        bus(1, 5'h10, 100, rd, acc);
        bus(1, 5'h04, 1, rd, acc);
        check("sticky_irq_clr", {63'd0, timer_interrupt}, 64'd0);
        bus(0, 5'h04, 0, rd, acc);
        check("sticky_cleared", {32'd0, rd}, 64'd0);

        // Write to MTIME_LO landing exactly on a tick edge.
        bus(1, 5'h00, 0, rd, acc);
        bus(1, 5'h10, 32'hFFFF_FFFF, rd, acc);
        bus(1, 5'h14, 32'hFFFF_FFFF, rd, acc);
        bus(1, 5'h08, 0, rd, acc);
        bus(1, 5'h0C, 0, rd, acc);
        bus(1, 5'h00, 32'h0301, rd, e);
        goto_accept(e + 8);
        bus(1, 5'h08, 50, rd, acc);
        check("coll_accept_edge", 64'(acc), 64'(e + 8));
        bus(0, 5'h08, 0, rd, acc);
        check("coll_mtime", {32'd0, rd}, 64'd50);

        // Unmapped addresses.
        bus(0, 5'h00, 0, rd, acc);
        check("ctrl_rb", {32'd0, rd}, 64'h0301);
        bus(0, 5'h18, 0, rd, acc);
        check("unmapped_rd", {32'd0, rd}, 64'd0);
        bus(1, 5'h1C, 32'hFFFF_FFFF, rd, acc);
        bus(0, 5'h1C, 0, rd, acc);
        check("unmapped_rd2", {32'd0, rd}, 64'd0);
        bus(0, 5'h00, 0, rd, acc);
        check("unmapped_no_side", {32'd0, rd}, 64'h0301);

        // Reset in the middle of a response, with the interrupt active.
        bus(1, 5'h00, 0, rd, acc);
        bus(1, 5'h10, 0, rd, acc);
        bus(1, 5'h14, 0, rd, acc);
        bus(1, 5'h00, 32'h05, rd, acc);
        @(negedge clk);
        check("pre_rst_irq", {63'd0, timer_interrupt}, 64'd1);
        req = 1'b1; we = 1'b0; addr = 5'h14;
        @(posedge clk);
        #1;
        check("pre_rst_ack", {63'd0, ack}, 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_ack", {63'd0, ack}, 64'd0);
        check("midrst_irq", {63'd0, timer_interrupt}, 64'd0);
        check("midrst_rdata", {32'd0, rdata}, 64'd0);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("midrst_no_ack", {63'd0, ack}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        bus(0, 5'h00, 0, rd, acc); check("post_rst_ctrl", {32'd0, rd}, 64'h0);
        bus(0, 5'h14, 0, rd, acc); check("post_rst_cmp_hi", {32'd0, rd}, 64'hFFFF_FFFF);
        bus(0, 5'h08, 0, rd, acc); check("post_rst_mtime", {32'd0, rd}, 64'h0);
        bus(0, 5'h04, 0, rd, acc); check("post_rst_status", {32'd0, rd}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Memory-mapped controller for the core's machine timer. It holds a 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register, a prescaler and control/status registers, all behind a simple request/acknowledge register port. It drives `timer_interrupt` into the CSR/interrupt logic of the pipelined core, so software can configure the timer at run time instead of relying on a fixed limit.

## Interface
- `PRESCALE_RST`, default 0: reset value of `CTRL.prescale`. `mtime` advances once every `prescale+1` enabled cycles.
- `CMP_RST`, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`. The default prevents an interrupt after reset.
- `clk` input, 1 bit: single clock. All state is updated on `posedge clk`.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `req` input, 1 bit: register access request. Held high until `ack`.
- `we` input, 1 bit: 1 means write, 0 means read. Sampled with `req`.
- `addr` input, 5 bits: byte address, word aligned. `addr[1:0]` is ignored.
- `wdata` input, 32 bits: write data.
- `rdata` output, 32 bits: read data, valid while `ack`=1.
- `ack` output, 1 bit: one-cycle completion pulse.
- `timer_interrupt` output, 1 bit: machine timer interrupt level.

## Operation
Register map:
- 0x00 `CTRL`, RW.
  - bit0 `en`: counting enable.
  - bit1 `auto_reload`.
  - bit2 `irq_en`.
  - bits[15:8] `prescale`.
  - Other bits read 0.
- 0x04 `STATUS`.
  - bit0 `pending`.
  - Writing 1 clears `pending`; writing 0 has no effect.
  - Other bits read 0.
- 0x08 `MTIME_LO`, RW. A read also latches `mtime[63:32]` into `hi_shadow`.
- 0x0C `MTIME_HI`.
  - A read returns `hi_shadow`, not the live value.
  - A write sets `mtime[63:32]`.
- 0x10 `MTIMECMP_LO`, RW.
- 0x14 `MTIMECMP_HI`, RW.
- 0x18–0x1C are unmapped. Reads return 0, writes are ignored, and `ack` is still given.

Access FSM (two states):
- IDLE:
  - If `req`=1, the access is accepted at this edge.
  - A write updates the target register at this edge.
  - For a read, `rdata` is registered from the target at this edge.
  - The FSM then moves to RESP.
- RESP:
  - `ack`=1 for exactly one cycle, then the FSM returns to IDLE.
  - `req` still high in the RESP cycle is not a new request. The requester drops `req` in the `ack` cycle.
  - The minimum spacing between accepted requests is 2 cycles.

Prescaler and counter:
- An 8-bit `pcnt` increments every cycle while `en`=1.
- `tick` = `en` & (`pcnt` == `prescale`). On `tick`, `pcnt` returns to 0.
- `en`=0 freezes `mtime` and holds `pcnt` at 0.
- On `tick`:
  - If `auto_reload`=1 and `mtime` >= `mtimecmp`, then `mtime` <= 0.
  - Otherwise `mtime` <= `mtime`+1, modulo 2^64. 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- The compare is an unsigned 64-bit `mtime` >= `mtimecmp`, evaluated on the registered values every cycle.

Pending and interrupt:
- `pending` sets at any edge where `en`=1 and the compare is true.
- In non-reload mode, `pending` therefore re-sets immediately after a clear while the compare stays true. Software must advance `mtimecmp` before clearing.
- `timer_interrupt` = `pending` & `irq_en`.
- `pending` is updated even when `irq_en`=0, so it can be polled.

Priority when events coincide:
- A bus write to `MTIME_LO` or `MTIME_HI` in the same cycle as a `tick` wins. The written half takes `wdata` and the other half holds its value; no increment or reload is applied that cycle.
- A STATUS write-1 clear in the same cycle as a set condition: set wins.
- Writing `prescale` resets `pcnt` to 0.

## Timing
- All outputs reset to 0: `ack`, `rdata`, `timer_interrupt`.
- Internal reset values:
  - `pending`, `mtime`, `hi_shadow` = 0.
  - `CTRL` = {`PRESCALE_RST`, 5'b0, 3'b000}.
  - `mtimecmp` = `CMP_RST`.
  - FSM = IDLE.
- Bus latency: `ack` and `rdata` appear 1 cycle after the accept edge. A write is visible internally from the accept edge.
- With `prescale`=P, `mtime` increments every P+1 cycles. The first increment comes P+1 edges after `en` is set.
- `pending` goes high 1 edge after `mtime` first equals `mtimecmp`, and `timer_interrupt` in the same cycle when `irq_en`=1.
- Reset asserted mid-access aborts the access: `ack` is not issued and all registers return to their reset values asynchronously.

## Test plan
- **Reset defaults.** Assert `rst` mid-RESP → `ack`=0 and `timer_interrupt`=0 immediately. After release, read `CTRL` = 0x0000_0000 and `MTIMECMP_HI` = 0xFFFF_FFFF, each with one `ack` pulse.
- **Periodic interrupt, auto-reload.** Write `MTIMECMP_LO`=4, `MTIMECMP_HI`=0, `CTRL`=0x07 (P=0) → `mtime` sequence 0,1,2,3,4,0,… `timer_interrupt` rises 1 cycle after `mtime`=4. Clearing `STATUS` drops it; it returns 5 ticks later.
- **Prescaler.** `CTRL`=0x0301 (P=3, `en`) → `mtime` increments every 4 cycles. After 40 cycles, a read of `MTIME_LO` returns 10.
- **Atomic 64-bit read across wrap.** Write `MTIME_HI`=0, `MTIME_LO`=0xFFFF_FFFF, then enable. Read `MTIME_LO` before the tick (returns 0xFFFF_FFFF); let the tick occur; read `MTIME_HI` → 0 (shadow), not 1.
- **Non-reload sticky compare.** `mtimecmp`=2, `CTRL`=0x05. Clear `pending` while `mtime`≥2 → `pending` re-sets next cycle. Write `MTIMECMP_LO`=100, then clear → stays 0.
- **Collisions.**
  - `MTIME_LO` write of 50 on a tick cycle → reads back 50, not 51.
  - STATUS clear coinciding with a set condition → `pending` stays 1.
  - Unmapped address 0x18 → `ack` pulses and `rdata`=0.
